// File: rtl/cs42448_adc_rx.sv
// cs42448_adc_rx: I2S capture of the three CS42448 stereo ADC serial lines
// into six DATA_W-bit two's-complement parallel samples.
// SCLK/LRCK arrive already synchronous to sys_clk, so edges are detected
// with a single register stage and no synchroniser.
// Optional feature: define CS42448_ADC_HPF_EN to insert a per-channel DC
// blocker in front of the output registers (adds one cycle of latency).
module cs42448_adc_rx #(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 32,
  parameter int HPF_SHIFT = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_done,
  input  logic              adc_sclk,
  input  logic              adc_lrck,
  input  logic              ADC_SDIN_CH0,
  input  logic              ADC_SDIN_CH1,
  input  logic              ADC_SDIN_CH2,
  output logic [DATA_W-1:0] adc_dout_l0,
  output logic [DATA_W-1:0] adc_dout_r0,
  output logic [DATA_W-1:0] adc_dout_l1,
  output logic [DATA_W-1:0] adc_dout_r1,
  output logic [DATA_W-1:0] adc_dout_l2,
  output logic [DATA_W-1:0] adc_dout_r2,
  output logic              adc_valid,
  output logic              frame_err
);

  localparam int NPAIR = 3;
  localparam int NCH   = 2 * NPAIR;
  localparam int CNT_W = $clog2(SLOT_W + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CAP_L = 2'd2,
    CAP_R = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic sclk_prev_q, lrck_prev_q;
  logic sclk_rise, lrck_fall, lrck_rise, lrck_edge;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_short;

  logic [NPAIR-1:0][DATA_W-1:0] shift_q, shift_d;
  logic [NPAIR-1:0][DATA_W-1:0] lhold_q, lhold_d;
  logic                         bad_q, bad_d;
  logic                         frame_err_q, frame_err_d;
  logic                         commit;
  logic [NPAIR-1:0]             sdin;

  logic [NCH-1:0][DATA_W-1:0]   cap_vec;
  logic [NCH-1:0][DATA_W-1:0]   out_q, out_d;
  logic                         valid_q, valid_d;

  assign sdin = {ADC_SDIN_CH2, ADC_SDIN_CH1, ADC_SDIN_CH0};

  // Edge detection against the one-cycle-delayed copies of SCLK and LRCK.
  always_comb begin
    sclk_rise = adc_sclk & ~sclk_prev_q;
    lrck_fall = ~adc_lrck & lrck_prev_q;
    lrck_rise = adc_lrck & ~lrck_prev_q;
    lrck_edge = lrck_fall | lrck_rise;
  end

  // Frame FSM, bit counter, shift registers and slot-boundary bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    lhold_d     = lhold_q;
    bad_d       = bad_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;
    slot_short  = (cnt_q < CNT_FULL);

    if (!init_done) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      lhold_d = '0;
      bad_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SYNC;
        end
        SYNC: begin
          if (lrck_fall) begin
            state_d = CAP_L;
            cnt_d   = sclk_rise ? CNT_ONE : '0;
            shift_d = '0;
            bad_d   = 1'b0;
          end
        end
        CAP_L, CAP_R: begin
          if (lrck_edge) begin
            cnt_d   = sclk_rise ? CNT_ONE : '0;
            shift_d = '0;
            if (slot_short) begin
              frame_err_d = 1'b1;
            end
            if ((state_q == CAP_L) && lrck_rise) begin
              state_d = CAP_R;
              if (slot_short) begin
                bad_d = 1'b1;
              end else begin
                lhold_d = shift_q;
              end
            end else if ((state_q == CAP_R) && lrck_fall) begin
              state_d = CAP_L;
              commit  = !slot_short && !bad_q;
              bad_d   = 1'b0;
            end
          end else if (sclk_rise) begin
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
            if ((cnt_q >= CNT_ONE) && (cnt_q <= CNT_LAST)) begin
              for (int p = 0; p < NPAIR; p++) begin
                shift_d[p] = {shift_q[p][DATA_W-2:0], sdin[p]};
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Interleave the captured slots into output-channel order (l0, r0, l1, ...).
  always_comb begin
    cap_vec = '0;
    for (int p = 0; p < NPAIR; p++) begin
      cap_vec[2*p]   = lhold_q[p];
      cap_vec[2*p+1] = shift_q[p];
    end
  end

  // Capture-side state registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      lhold_q     <= '0;
      bad_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= adc_sclk;
      lrck_prev_q <= adc_lrck;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      lhold_q     <= lhold_d;
      bad_q       <= bad_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef CS42448_ADC_HPF_EN
  localparam int ACC_W  = DATA_W + HPF_SHIFT + 1;
  localparam int DIFF_W = ACC_W + 1;

  logic                       pend_q;
  logic [NCH-1:0][DATA_W-1:0] raw_q, raw_d;
  logic [NCH-1:0][ACC_W-1:0]  acc_q, acc_d;

  logic signed [DIFF_W-1:0]   x_ext, x_shl, acc_ext, diff, acc_sum, y_full;
  logic [DIFF_W-DATA_W:0]     y_top;
  logic [DATA_W-1:0]          y_sat;

  // Latch the committed raw samples so the filter runs one cycle later.
  always_comb begin
    raw_d = commit ? cap_vec : raw_q;
  end

  // DC blocker: leaky integrator tracks the mean, output is input minus mean.
  always_comb begin
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = pend_q;
    x_ext   = '0;
    x_shl   = '0;
    acc_ext = '0;
    diff    = '0;
    acc_sum = '0;
    y_full  = '0;
    y_top   = '0;
    y_sat   = '0;
    for (int i = 0; i < NCH; i++) begin
      x_ext   = {{(DIFF_W-DATA_W){raw_q[i][DATA_W-1]}}, raw_q[i]};
      x_shl   = x_ext <<< HPF_SHIFT;
      acc_ext = {acc_q[i][ACC_W-1], acc_q[i]};
      diff    = x_shl - acc_ext;
      acc_sum = acc_ext + (diff >>> HPF_SHIFT);
      y_full  = x_ext - (acc_sum >>> HPF_SHIFT);
      y_top   = y_full[DIFF_W-1:DATA_W-1];
      if ((&y_top) || (~|y_top)) begin
        y_sat = y_full[DATA_W-1:0];
      end else if (y_full[DIFF_W-1]) begin
        y_sat = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        y_sat = {1'b0, {(DATA_W-1){1'b1}}};
      end
      if (pend_q) begin
        acc_d[i] = acc_sum[ACC_W-1:0];
        out_d[i] = y_sat;
      end
    end
  end

  // Filter pipeline and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_q  <= 1'b0;
      raw_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= commit;
      raw_q   <= raw_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end
`else
  // Raw path: all six outputs load together on a frame commit.
  always_comb begin
    out_d   = commit ? cap_vec : out_q;
    valid_d = commit;
  end

  // Output registers; they hold their value between commits.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end
`endif

  assign adc_dout_l0 = out_q[0];
  assign adc_dout_r0 = out_q[1];
  assign adc_dout_l1 = out_q[2];
  assign adc_dout_r1 = out_q[3];
  assign adc_dout_l2 = out_q[4];
  assign adc_dout_r2 = out_q[5];
  assign adc_valid   = valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_cs42448_adc_rx.sv
// tb_cs42448_adc_rx: directed bench for the CS42448 ADC I2S capture block.
// The bench plays the codec: it drives SCLK/LRCK/SDIN with LRCK and data
// changing on SCLK falling edges and checks samples, pulses and latency.
module tb_cs42448_adc_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_done;
  logic        adc_sclk;
  logic        adc_lrck;
  logic [2:0]  sdin;
  logic [15:0] adc_dout_l0, adc_dout_r0, adc_dout_l1, adc_dout_r1;
  logic [15:0] adc_dout_l2, adc_dout_r2;
  logic        adc_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int validCount = 0;
  int ferrCount = 0;
  int rstAt = -1;
  int initLowAt = -1;
  int initHighAt = -1;

  logic [5:0][15:0] doutAll;
  assign doutAll = {adc_dout_r2, adc_dout_l2, adc_dout_r1, adc_dout_l1, adc_dout_r0, adc_dout_l0};

  cs42448_adc_rx dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .init_done    (init_done),
    .adc_sclk     (adc_sclk),
    .adc_lrck     (adc_lrck),
    .ADC_SDIN_CH0 (sdin[0]),
    .ADC_SDIN_CH1 (sdin[1]),
    .ADC_SDIN_CH2 (sdin[2]),
    .adc_dout_l0  (adc_dout_l0),
    .adc_dout_r0  (adc_dout_r0),
    .adc_dout_l1  (adc_dout_l1),
    .adc_dout_r1  (adc_dout_r1),
    .adc_dout_l2  (adc_dout_l2),
    .adc_dout_r2  (adc_dout_r2),
    .adc_valid    (adc_valid),
    .frame_err    (frame_err)
  );

  // 100 MHz system clock
  always #5 sys_clk = ~sys_clk;

  // Count output pulses away from the active edge
  always @(negedge sys_clk) begin
    if (adc_valid === 1'b1) validCount++;
    if (frame_err === 1'b1) ferrCount++;
  end

  // Safety net so the run always ends
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [2:0][15:0] expL, input logic [2:0][15:0] expR);
    for (int p = 0; p < 3; p++) begin
      checkOutput($sformatf("%s L%0d", tag, p), doutAll[2*p], expL[p]);
      checkOutput($sformatf("%s R%0d", tag, p), doutAll[2*p+1], expR[p]);
    end
  endtask

  // Send one I2S slot of nbits SCLK periods; bit 0 is the delay bit, bits
  // 1..16 carry the word MSB first, later bits are filler ones.
  // expValid >= 0 checks adc_valid around the LRCK edge at the slot start.
  task automatic applyStimulus(input logic lr, input logic [2:0][15:0] data,
                               input int nbits, input int expValid);
    logic [2:0] bits;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < 3; c++) bits[c] = (k >= 1 && k <= 16) ? data[c][16-k] : 1'b1;
      @(posedge sys_clk); #1;
      adc_sclk = 1'b0;
      adc_lrck = lr;
      sdin     = bits;
      if (k == 0 && expValid >= 0) begin
        @(negedge sys_clk);
        checkOutput("valid before commit", {15'd0, adc_valid}, 16'd0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        checkOutput("valid after lrck edge", {15'd0, adc_valid}, 16'(expValid));
      end else begin
        @(posedge sys_clk);
      end
      @(posedge sys_clk); #1;
      adc_sclk = 1'b1;
      if (k == rstAt) sys_rst = 1'b1;
      if (k == initLowAt) init_done = 1'b0;
      if (k == initHighAt) init_done = 1'b1;
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
    end
  endtask

  logic [2:0][15:0] aL, aR, bL, bR, cL, cR, dL, dR, eL, eR, zero3;
  int vBase, fBase;

  initial begin
    aL = {16'h0000, 16'h1234, 16'h8001};
    aR = {16'hFFFF, 16'hABCD, 16'h7FFE};
    bL = {16'h0F0F, 16'hC3C3, 16'h5555};
    bR = {16'h00FF, 16'h3C3C, 16'hAAAA};
    cL = {16'h0001, 16'h8000, 16'h7FFF};
    cR = {16'hFFFE, 16'h0123, 16'hFEDC};
    dL = {16'hDEAD, 16'hBEEF, 16'hCAFE};
    dR = {16'h1357, 16'h2468, 16'h9999};
    eL = {16'h2468, 16'h1357, 16'h9ABC};
    eR = {16'hF00D, 16'h0BAD, 16'h5A5A};
    zero3 = '0;

    sys_rst = 1'b1; init_done = 1'b0; adc_sclk = 1'b0; adc_lrck = 1'b1; sdin = 3'b000;
    repeat (4) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    $display("[TB] reset state");
    checkFrame("reset", zero3, zero3);
    checkOutput("reset valid", {15'd0, adc_valid}, 16'd0);
    checkOutput("reset frame_err", {15'd0, frame_err}, 16'd0);

    init_done = 1'b1;
    repeat (3) @(posedge sys_clk);

    $display("[TB] three clean frames");
    applyStimulus(1'b0, aL, 32, 0);
    applyStimulus(1'b1, aR, 32, -1);
    applyStimulus(1'b0, aL, 32, 1);
    checkFrame("frame1", aL, aR);
    applyStimulus(1'b1, aR, 32, -1);
    applyStimulus(1'b0, bL, 32, 1);
    checkFrame("frame2", aL, aR);
    applyStimulus(1'b1, bR, 32, -1);
    checkOutput("pulses after two commits", 16'(validCount), 16'd2);

    $display("[TB] short left slot");
    fBase = ferrCount;
    applyStimulus(1'b0, dL, 10, 1);
    checkFrame("frame3", bL, bR);
    applyStimulus(1'b1, dR, 32, -1);
    checkOutput("frame_err pulses for short slot", 16'(ferrCount - fBase), 16'd1);
    applyStimulus(1'b0, cL, 32, 0);
    checkFrame("held after drop", bL, bR);
    applyStimulus(1'b1, cR, 32, -1);
    applyStimulus(1'b0, eL, 32, 1);
    checkFrame("recovered frame", cL, cR);

    $display("[TB] reset mid right slot");
    vBase = validCount;
    rstAt = 8;
    applyStimulus(1'b1, eR, 32, -1);
    rstAt = -1;
    checkFrame("after mid-frame reset", zero3, zero3);
    applyStimulus(1'b0, bL, 32, 0);
    applyStimulus(1'b1, bR, 32, -1);
    checkOutput("no pulse for reset frame", 16'(validCount - vBase), 16'd0);
    applyStimulus(1'b0, dL, 32, 1);
    checkFrame("capture after reset", bL, bR);

    $display("[TB] init_done drop and mid-slot restart");
    fBase = ferrCount;
    initLowAt = 8;
    applyStimulus(1'b0, dL, 32, -1);
    initLowAt = -1;
    // Finish the left slot above with init low, then restart in the right slot
    checkFrame("held while init low", bL, bR);
    initHighAt = 12;
    applyStimulus(1'b1, dR, 32, -1);
    initHighAt = -1;
    applyStimulus(1'b0, eL, 32, 0);
    applyStimulus(1'b1, eR, 32, -1);
    applyStimulus(1'b0, aL, 32, 1);
    checkFrame("resynced frame", eL, eR);
    checkOutput("no frame_err on restart", 16'(ferrCount - fBase), 16'd0);

    checkOutput("total valid pulses", 16'(validCount), 16'd6);
    checkOutput("total frame_err pulses", 16'(ferrCount), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
